// File: rtl/rr_miso_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rr_miso_fifo
// Purpose  : CHANNEL independent FIFOs merged by a round-robin arbiter into
//            one registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module rr_miso_fifo #(
  parameter int CHANNEL_BIT = 2,
  parameter int SIZE_BIT    = 3,
  parameter int WIDTH       = 8,
  parameter int AFULL_LEVEL = 6,
  localparam int CHANNEL    = 1 << CHANNEL_BIT,
  localparam int CW         = SIZE_BIT + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CHANNEL-1:0]       write_flags,
  input  logic [CHANNEL*WIDTH-1:0] write_datas,
  input  logic [CHANNEL-1:0]       flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [CHANNEL_BIT-1:0]   out_channel,
  output logic [CHANNEL-1:0]       empty,
  output logic [CHANNEL-1:0]       full,
  output logic [CHANNEL-1:0]       almost_full,
  output logic [CHANNEL-1:0]       overflow,
  output logic [CHANNEL*CW-1:0]    counts
);

  localparam int            DEPTH     = 1 << SIZE_BIT;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [CHANNEL-1:0]       eligible;
  logic [CHANNEL-1:0]       pop;
  logic [CHANNEL*WIDTH-1:0] heads;
  logic [CHANNEL_BIT-1:0]   last_grant;
  logic [CHANNEL_BIT-1:0]   grant;
  logic [CHANNEL_BIT-1:0]   scan_idx;
  logic                     any_eligible;
  logic                     load;

  generate
    for (genvar i = 0; i < CHANNEL; i++) begin : g_chan
      logic [WIDTH-1:0]    mem [DEPTH];
      logic [SIZE_BIT-1:0] wptr;
      logic [SIZE_BIT-1:0] rptr;
      logic [CW-1:0]       cnt;
      logic                wr_ok;

      assign empty[i]       = (cnt == '0);
      assign full[i]        = (cnt == FULL_CNT);
      assign almost_full[i] = (cnt >= AFULL_CNT);
      assign counts[i*CW +: CW]       = cnt;
      assign heads[i*WIDTH +: WIDTH]  = mem[rptr];
      assign eligible[i]    = (cnt != '0) && !flush[i];
      assign pop[i]         = load && (grant == CHANNEL_BIT'(i));
      // Fullness is judged on the registered count, so a pop never frees room
      // for a write in the same cycle.
      assign wr_ok          = write_flags[i] && !full[i] && !flush[i];

      always_ff @(posedge CLK) begin
        if (wr_ok) mem[wptr] <= write_datas[i*WIDTH +: WIDTH];
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          wptr        <= '0;
          rptr        <= '0;
          cnt         <= '0;
          overflow[i] <= 1'b0;
        end else if (flush[i]) begin
          wptr        <= '0;
          rptr        <= '0;
          cnt         <= '0;
          overflow[i] <= 1'b0;
        end else begin
          if (wr_ok) wptr <= wptr + 1'b1;
          if (pop[i]) rptr <= rptr + 1'b1;
          case ({wr_ok, pop[i]})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
          endcase
          if (write_flags[i] && full[i]) overflow[i] <= 1'b1;
        end
      end
    end
  endgenerate

  // Scan from last_grant+1 upward, wrapping; the last slot is last_grant itself.
  always_comb begin
    grant        = '0;
    any_eligible = 1'b0;
    scan_idx     = '0;
    for (int k = 1; k <= CHANNEL; k++) begin
      scan_idx = last_grant + CHANNEL_BIT'(k);
      if (!any_eligible && eligible[scan_idx]) begin
        grant        = scan_idx;
        any_eligible = 1'b1;
      end
    end
  end

  assign load = (!out_valid || out_ready) && any_eligible;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      last_grant  <= CHANNEL_BIT'(CHANNEL - 1);
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= heads[grant*WIDTH +: WIDTH];
      out_channel <= grant;
      last_grant  <= grant;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_miso_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_miso_fifo
// Purpose  : Directed self-checking bench for rr_miso_fifo (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_miso_fifo;

  logic        CLK;
  logic        RST;
  logic [3:0]  write_flags;
  logic [31:0] write_datas;
  logic [3:0]  flush;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_channel;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  almost_full;
  logic [3:0]  overflow;
  logic [15:0] counts;

  int total = 0;
  int bad   = 0;

  rr_miso_fifo dut (
    .CLK(CLK), .RST(RST),
    .write_flags(write_flags), .write_datas(write_datas),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .counts(counts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(counts[ch*4 +: 4]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    write_flags = '0;
    write_datas = '0;
    flush       = '0;
    out_ready   = 1'b0;
    RST         = 1'b0;
    #3;
    RST         = 1'b1;
  endtask

  initial begin
    write_flags = '0;
    write_datas = '0;
    flush       = '0;
    out_ready   = 1'b0;
    RST         = 1'b0;
    #12;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_chan", out_channel, 0);
    check_val("rst_empty", empty, 4'hF);
    check_val("rst_full", full, 0);
    check_val("rst_afull", almost_full, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_counts", counts, 0);
    RST = 1'b1;

    // Single word latency through channel 2
    tick();
    write_flags = 4'b0100;
    write_datas = 32'h0011_0000;
    out_ready   = 1'b1;
    tick();
    write_flags = '0;
    check_val("lat_cnt2_e1", cnt_of(2), 1);
    check_val("lat_valid_e1", out_valid, 0);
    tick();
    check_val("lat_valid_e2", out_valid, 1);
    check_val("lat_data_e2", out_data, 8'h11);
    check_val("lat_chan_e2", out_channel, 2);
    check_val("lat_cnt2_e2", cnt_of(2), 0);
    tick();
    check_val("lat_valid_drop", out_valid, 0);
    check_val("lat_data_keep", out_data, 8'h11);

    // Round-robin order A0,B0,D0,A1,D1
    do_reset();
    tick();
    write_flags = 4'b1011;
    write_datas = 32'hD0_00_B0_A0;
    tick();
    write_flags = 4'b1001;
    write_datas = 32'hD1_00_00_A1;
    tick();
    write_flags = '0;
    check_val("rr_stage0", out_data, 8'hA0);
    out_ready = 1'b1;
    begin
      logic [7:0] exp_d [4];
      logic [1:0] exp_c [4];
      exp_d = '{8'hB0, 8'hD0, 8'hA1, 8'hD1};
      exp_c = '{2'd1, 2'd3, 2'd0, 2'd3};
      for (int j = 0; j < 4; j++) begin
        tick();
        check_val($sformatf("rr_data%0d", j), out_data, exp_d[j]);
        check_val($sformatf("rr_chan%0d", j), out_channel, exp_c[j]);
        check_val($sformatf("rr_valid%0d", j), out_valid, 1);
      end
    end
    tick();
    check_val("rr_done", out_valid, 0);

    // Fill channel 1; first word is pulled into the empty output stage
    do_reset();
    tick();
    for (int k = 1; k <= 9; k++) begin
      int expc;
      write_flags = 4'b0010;
      write_datas = 32'(8'h40 + k - 1) << 8;
      tick();
      expc = (k == 1) ? 1 : k - 1;
      check_val($sformatf("fill_cnt%0d", k), cnt_of(1), expc);
      check_val($sformatf("fill_af%0d", k), almost_full[1], (expc >= 6) ? 1 : 0);
      check_val($sformatf("fill_full%0d", k), full[1], (expc == 8) ? 1 : 0);
    end
    check_val("fill_noovf", overflow[1], 0);
    write_datas = 32'h0000_EE00;
    tick();
    check_val("ovf_set", overflow[1], 1);
    check_val("ovf_cnt", cnt_of(1), 8);
    out_ready = 1'b1;
    tick();
    write_flags = '0;
    out_ready   = 1'b0;
    check_val("fullpop_cnt", cnt_of(1), 7);
    check_val("fullpop_data", out_data, 8'h41);
    check_val("fullpop_ovf", overflow[1], 1);

    // Hold stable under back-pressure while other channels fill
    for (int j = 0; j < 5; j++) begin
      write_flags = 4'b1101;
      write_datas = {8'hD0 + 8'(j), 8'hC0 + 8'(j), 8'h00, 8'hA0 + 8'(j)};
      tick();
      check_val($sformatf("hold_data%0d", j), out_data, 8'h41);
      check_val($sformatf("hold_chan%0d", j), out_channel, 1);
    end
    write_flags = '0;
    out_ready   = 1'b1;
    tick();
    check_val("resume_chan2", out_channel, 2);
    check_val("resume_data2", out_data, 8'hC0);
    tick();
    check_val("resume_chan3", out_channel, 3);
    check_val("resume_data3", out_data, 8'hD0);
    tick();
    check_val("resume_chan0", out_channel, 0);
    check_val("resume_data0", out_data, 8'hA0);
    tick();
    check_val("resume_chan1", out_channel, 1);
    check_val("resume_data1", out_data, 8'h42);

    // Flush with a staged word and a same-cycle write
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      write_flags = 4'b0001;
      write_datas = 32'(8'h50 + k);
      tick();
    end
    check_val("fl_pre_cnt", cnt_of(0), 2);
    check_val("fl_pre_data", out_data, 8'h50);
    flush       = 4'b0001;
    write_datas = 32'h0000_00EE;
    tick();
    flush       = '0;
    write_flags = '0;
    check_val("fl_cnt", cnt_of(0), 0);
    check_val("fl_ovf", overflow[0], 0);
    check_val("fl_valid", out_valid, 1);
    check_val("fl_data", out_data, 8'h50);
    out_ready = 1'b1;
    tick();
    check_val("fl_drain_valid", out_valid, 0);
    check_val("fl_lost_cnt", cnt_of(0), 0);
    check_val("fl_empty", empty[0], 1);

    // Asynchronous reset mid-stream
    do_reset();
    tick();
    write_flags = 4'b1010;
    write_datas = 32'h63_00_61_00;
    tick();
    write_flags = '0;
    tick();
    check_val("ar_pre_valid", out_valid, 1);
    check_val("ar_pre_chan", out_channel, 1);
    #2;
    RST = 1'b0;
    #1;
    check_val("ar_valid", out_valid, 0);
    check_val("ar_data", out_data, 0);
    check_val("ar_chan", out_channel, 0);
    check_val("ar_counts", counts, 0);
    check_val("ar_empty", empty, 4'hF);
    #2;
    RST = 1'b1;
    write_flags = 4'b1100;
    write_datas = 32'h73_72_00_00;
    out_ready   = 1'b1;
    tick();
    write_flags = '0;
    tick();
    check_val("ar_first_chan", out_channel, 2);
    check_val("ar_first_data", out_data, 8'h72);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
